// File: rtl/vppm_rx_pkg.sv
// Shared VPPM receive-path types and default constants.
package vppm_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    DATA  = 2'd2
  } syncState_t;

  localparam int NBITS_DEF        = 12;
  localparam int PREAMBLE_MIN_DEF = 5;
  localparam int GAP_TIMEOUT_DEF  = 1024;

endpackage

// File: rtl/bit_gap_timer.sv
// Counts idle clk cycles between bit strobes.
// Pulses expire when the idle run reaches GAP_TIMEOUT-1.
module bit_gap_timer
  import vppm_rx_pkg::*;
#(
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(GAP_TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(GAP_TIMEOUT - 1);

  logic [TW-1:0] count;

  assign expire = enable && !clear && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable || expire)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/vppm_frame_sync.sv
// VPPM frame synchroniser: preamble/sync hunt, then
// MSB-first deserialisation into a handshaked word register.
module vppm_frame_sync
  import vppm_rx_pkg::*;
#(
  parameter int NBITS        = NBITS_DEF,
  parameter int PREAMBLE_MIN = PREAMBLE_MIN_DEF,
  parameter int GAP_TIMEOUT  = GAP_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             freq_available,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             locked,
  output logic             overrun,
  output logic [15:0]      word_count
);

  localparam int BW = $clog2(NBITS + 1);
  localparam int ZW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [ZW-1:0] ZERO_GOAL = ZW'(PREAMBLE_MIN - 1);
  localparam logic [ZW-1:0] ZERO_SAT = ZW'(PREAMBLE_MIN);

  syncState_t       state;
  logic [BW-1:0]    bitCnt;
  logic [ZW-1:0]    zeroCnt;
  logic [NBITS-2:0] shiftReg;
  logic [NBITS-1:0] nextWord;
  logic             gapExpire;

  assign nextWord = {shiftReg, bit_in};
  assign locked   = (state == DATA);

  bit_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clear (bit_valid),
    .enable((state != HUNT) && freq_available),
    .expire(gapExpire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      bitCnt     <= '0;
      zeroCnt    <= '0;
      shiftReg   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      word_count <= '0;
    end else begin
      if (data_valid && data_ready)
        data_valid <= 1'b0;
      // Aborts keep the output side intact.
      if (!freq_available || gapExpire) begin
        state    <= HUNT;
        bitCnt   <= '0;
        zeroCnt  <= '0;
        shiftReg <= '0;
      end else if (bit_valid) begin
        unique case (state)
          HUNT: begin
            if (bit_in) begin
              zeroCnt <= '0;
            end else if (zeroCnt == ZERO_GOAL) begin
              zeroCnt <= ZERO_SAT;
              state   <= ARMED;
            end else begin
              zeroCnt <= zeroCnt + 1'b1;
            end
          end
          ARMED: begin
            if (bit_in) begin
              state    <= DATA;
              bitCnt   <= '0;
              zeroCnt  <= '0;
              shiftReg <= '0;
            end
          end
          DATA: begin
            if (bitCnt == LAST_BIT) begin
              bitCnt   <= '0;
              shiftReg <= '0;
              if (!data_valid || data_ready) begin
                data_out   <= nextWord;
                data_valid <= 1'b1;
                word_count <= word_count + 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= nextWord[NBITS-2:0];
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vppm_frame_sync.sv
// Directed scoreboard bench for vppm_frame_sync.
module tb_vppm_frame_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        freq_available = 1'b1;
  logic        data_ready = 1'b0;
  logic [11:0] data_out;
  logic        data_valid;
  logic        locked;
  logic        overrun;
  logic [15:0] word_count;

  int          compared = 0;
  int          mismatched = 0;
  logic [11:0] sb[$];
  logic [15:0] expCount = '0;

  always #5 clk = ~clk;

  vppm_frame_sync #(
    .NBITS(12),
    .PREAMBLE_MIN(5),
    .GAP_TIMEOUT(1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .freq_available(freq_available),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .locked        (locked),
    .overrun       (overrun),
    .word_count    (word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake completes at the coming posedge: pop and compare.
  always @(negedge clk) begin
    #1;
    if (!rst && data_valid === 1'b1 && data_ready === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        check("sb_word", {20'b0, data_out}, {20'b0, sb.pop_front()});
    end
  end

  task automatic sendBit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendWord(input logic [11:0] w, input logic rdyLast);
    for (int i = 11; i >= 0; i--) begin
      if (i == 0 && rdyLast) data_ready = 1'b1;
      sendBit(w[i]);
    end
  endtask

  task automatic lockUp();
    repeat (5) sendBit(1'b0);
    sendBit(1'b1);
  endtask

  task automatic dropFreq();
    bit_valid      = 1'b0;
    freq_available = 1'b0;
    @(negedge clk);
    freq_available = 1'b1;
  endtask

  initial begin
    // Reset, with a strobe that must be ignored.
    @(negedge clk);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bit_valid = 1'b0;
    check("rst_data", {20'b0, data_out}, 32'h0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_count", word_count, 16'h0);
    idle(2);

    // Basic frame.
    data_ready = 1'b1;
    lockUp();
    check("sync_locked", locked, 1'b1);
    sb.push_back(12'hA5C);
    expCount++;
    sendWord(12'hA5C, 1'b0);
    bit_valid = 1'b0;
    check("a5c_valid", data_valid, 1'b1);
    check("a5c_data", {20'b0, data_out}, 32'hA5C);
    check("a5c_count", word_count, expCount);
    idle(2);
    check("a5c_drained", data_valid, 1'b0);

    // Short preamble never locks.
    dropFreq();
    check("drop_locked", locked, 1'b0);
    repeat (4) sendBit(1'b0);
    sendBit(1'b1);
    sendWord(12'hFFF, 1'b0);
    idle(1);
    check("short_locked", locked, 1'b0);
    check("short_valid", data_valid, 1'b0);
    check("short_count", word_count, expCount);

    // Word completes in the handshake cycle.
    data_ready = 1'b0;
    lockUp();
    sb.push_back(12'h3C3);
    expCount++;
    sendWord(12'h3C3, 1'b0);
    check("hold_3c3", {20'b0, data_out}, 32'h3C3);
    sb.push_back(12'h5A5);
    expCount++;
    sendWord(12'h5A5, 1'b1);
    data_ready = 1'b0;
    bit_valid  = 1'b0;
    check("col_valid", data_valid, 1'b1);
    check("col_data", {20'b0, data_out}, 32'h5A5);
    check("col_overrun", overrun, 1'b0);
    check("col_count", word_count, expCount);
    data_ready = 1'b1;
    idle(2);
    check("col_drained", data_valid, 1'b0);

    // Overrun with consumer stalled.
    dropFreq();
    data_ready = 1'b0;
    lockUp();
    sb.push_back(12'h123);
    expCount++;
    sendWord(12'h123, 1'b0);
    sendWord(12'h456, 1'b0);
    sendWord(12'h789, 1'b0);
    bit_valid = 1'b0;
    check("ovr_data", {20'b0, data_out}, 32'h123);
    check("ovr_valid", data_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_count", word_count, expCount);
    data_ready = 1'b1;
    idle(1);
    check("ovr_released", data_valid, 1'b0);
    idle(3);
    check("ovr_no_more", data_valid, 1'b0);

    // Gap timeout.
    dropFreq();
    lockUp();
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    bit_valid = 1'b0;
    repeat (1023) @(negedge clk);
    check("to_locked_1023", locked, 1'b1);
    @(negedge clk);
    check("to_locked_1024", locked, 1'b0);
    lockUp();
    sb.push_back(12'h0F0);
    expCount++;
    sendWord(12'h0F0, 1'b0);
    bit_valid = 1'b0;
    check("to_data", {20'b0, data_out}, 32'h0F0);
    check("to_valid", data_valid, 1'b1);
    check("to_count", word_count, expCount);
    idle(2);

    // Frequency lock lost mid-word.
    data_ready = 1'b0;
    dropFreq();
    lockUp();
    sb.push_back(12'h6B1);
    expCount++;
    sendWord(12'h6B1, 1'b0);
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    sendBit(1'b0); sendBit(1'b1);
    freq_available = 1'b0;
    bit_in         = 1'b0;
    bit_valid      = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    check("fd_locked", locked, 1'b0);
    check("fd_data", {20'b0, data_out}, 32'h6B1);
    check("fd_valid", data_valid, 1'b1);
    freq_available = 1'b1;
    repeat (7) sendBit(1'b1);
    idle(1);
    check("fd_nolock", locked, 1'b0);
    check("fd_count", word_count, expCount);
    data_ready = 1'b1;
    idle(1);
    lockUp();
    sb.push_back(12'h2D4);
    expCount++;
    sendWord(12'h2D4, 1'b0);
    idle(1);
    check("fd_data2", {20'b0, data_out}, 32'h2D4);
    check("fd_count2", word_count, expCount);

    // Reset while in DATA.
    data_ready = 1'b0;
    check("pre_rst_locked", locked, 1'b1);
    repeat (4) sendBit(1'b1);
    rst       = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bit_valid = 1'b0;
    check("mid_rst_data", {20'b0, data_out}, 32'h0);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_locked", locked, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_count", word_count, 16'h0);
    expCount   = 16'h0;
    data_ready = 1'b1;
    lockUp();
    sb.push_back(12'h801);
    expCount++;
    sendWord(12'h801, 1'b0);
    idle(2);
    check("post_rst_data", {20'b0, data_out}, 32'h801);
    check("post_rst_count", word_count, expCount);
    check("sb_empty_end", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vppm_frame_sync.md
# vppm_frame_sync

Frame synchroniser and deserialiser for the VPPM receive path. It sits directly downstream of the VPPM demodulator and consumes its serial bit stream plus a per-bit strobe. It hunts for the zero preamble and the sync bit, then packs every following NBITS bits into parallel words delivered over a valid/ready handshake. Lock is dropped on bit-stream stall or loss of frequency lock.

## Interface
- `NBITS`, 12: data word width; MSB received first.
- `PREAMBLE_MIN`, 5: minimum consecutive 0 bits before a sync 1 is accepted.
- `GAP_TIMEOUT`, 1024: `clk` cycles without `bit_valid` before lock is abandoned; ≥2.
- `clk`  in  1  system clock (200 MHz domain); single clock.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  demodulated VPPM bit; sampled only when `bit_valid`=1.
- `bit_valid`  in  1  one-cycle strobe per demodulated bit.
- `freq_available`  in  1  frequency-detector lock; 0 forces HUNT.
- `data_out`  out  NBITS  assembled word; stable while `data_valid`=1.
- `data_valid`  out  1  word available.
- `data_ready`  in  1  consumer accepts word.
- `locked`  out  1  high while in DATA state.
- `overrun`  out  1  sticky; a completed word was dropped.
- `word_count`  out  16  words loaded into output register, wraps 0xFFFF→0.

## Operation
- States: HUNT, ARMED, DATA.
- HUNT: zero counter (saturating at PREAMBLE_MIN) increments on each valid 0 and clears on valid 1; on the valid 0 that reaches PREAMBLE_MIN → ARMED.
- ARMED: valid 0 stays ARMED; valid 1 (sync) → DATA, bit counter = 0, shift register cleared; sync bit is not data.
- DATA: each valid bit shifts left into the shift register (new bit at LSB); on the NBITS-th bit the complete word is offered to the output register and the bit counter returns to 0. DATA persists indefinitely: words are back to back, with no re-sync.
- Output register: loads on word completion if `data_valid`=0 or the handshake (`data_valid`&`data_ready`) completes in the same cycle. Otherwise the new word is dropped, the held word is kept, and `overrun` is set.
- `word_count` increments on every load.
- Gap timer: runs in ARMED/DATA and clears on each `bit_valid`. If it reaches GAP_TIMEOUT-1 → HUNT, discarding the partial word and zero counter.
- `freq_available`=0 in any state → HUNT next cycle with the counters cleared. Bits are ignored while low.
- Abort to HUNT never clears the output register, `data_valid`, `overrun` or `word_count`.
- `bit_valid` is ignored in the cycle `rst` is high.

## Timing
- Reset values: state HUNT, `data_out`=0, `data_valid`=0, `locked`=0, `overrun`=0, `word_count`=0, all internal counters 0.
- Sync bit strobed at cycle t → `locked`=1 at t+1.
- Last data bit strobed at t → `data_out`/`data_valid` updated at t+1, `word_count` at t+1.
- Handshake at edge t (valid&ready) → `data_valid`=0 at t+1, unless a new word loads at the same edge, in which case `data_valid` stays 1 with the new data.
- Timeout: the last strobe at t with no further strobe → HUNT and `locked`=0 at t+GAP_TIMEOUT.
- `bit_valid` on consecutive cycles is legal (1 bit/cycle throughput).

## Structure
- Package `vppm_rx_pkg`: state enum (HUNT/ARMED/DATA) and default constants for NBITS, PREAMBLE_MIN, GAP_TIMEOUT, shared with the demodulator side.
- One sub-module: `bit_gap_timer` (clear/enable inputs, expiry pulse, width $clog2(GAP_TIMEOUT)).
- Widths: bit counter $clog2(NBITS+1), zero counter $clog2(PREAMBLE_MIN+1).

## Test plan
- Stimulus: 5 zeros, a 1, then 0xA5C (MSB first), `data_ready`=1. Response: `data_out`=0xA5C and `data_valid` one cycle after the last bit; `word_count`=1.
- Stimulus: 4 zeros, a 1, then 0xFFF. Response: stays in HUNT, no `data_valid`, `locked`=0.
- Stimulus: lock, then 3 words 0x123/0x456/0x789 with `data_ready`=0. Response: holds 0x123, `overrun`=1, `word_count`=1. Raising `data_ready` releases 0x123 only.
- Stimulus: lock, 6 data bits, then no strobe for 1024 cycles. Response: `locked`=0 at the 1024th cycle. A fresh preamble+sync+0x0F0 then yields exactly 0x0F0.
- Stimulus: `freq_available` dropped mid-word. Response: HUNT next cycle, partial word discarded, held output word unaffected.
- Stimulus: word completes in the same cycle as a handshake. Response: no overrun, `data_valid` stays 1 with the new word.
- Stimulus: `rst` asserted mid-DATA. Response: all outputs at reset values next cycle.
